mbt_pixel_engine: RTL and testbench
===================================

// Module: mbt_pixel_engine
// PURPOSE
//  Fixed-point Mandelbrot iteration engine that sits directly downstream of the pixel-sweep controller.
//  - Each start pulse hands over a pixel group: (i_x..i_x+3, i_y).
//  - Computes the escape count for all 4 pixels sequentially and writes each count to the frame-buffer write port.
//  - Pulses mbt_response once the whole group is written.
// PARAMETERS
//  FB_W     800     frame width in pixels; used for the address computation
//  ITER_W   8       escape-count width
//  MAX_ITER 255     iteration cap; must be < 2**ITER_W
//  ADDR_W   19      frame-buffer address width
//  X_MIN    -10240  c_re of pixel x=0, signed Q4.12 (-2.5)
//  X_STEP   18      c_re increment per pixel, Q4.12
//  Y_MIN    -5120   c_im of row y=0, signed Q4.12 (-1.25)
//  Y_STEP   17      c_im increment per row, Q4.12
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset, synchronous, active-high
//  soft_rst      in   1       controller-driven abort (rst_MBT); synchronous, active-high
//  start         in   1       group request; sampled only in IDLE
//  i_x           in   16      first pixel x of group (multiple of 4)
//  i_y           in   16      pixel row
//  mbt_response  out  1       one-cycle group-done pulse
//  busy          out  1       high in any state except IDLE
//  fb_we         out  1       frame-buffer write strobe
//  fb_addr       out  ADDR_W  write address
//  fb_data       out  ITER_W (4*ITER_W with pack)  escape count(s)
//  DBG_state     out  3       current FSM state
// BEHAVIOUR
//  - Reset: rst or soft_rst -> IDLE. All outputs registered and 0: mbt_response, busy, fb_we, fb_addr, fb_data. DBG_state=IDLE.
//  - Priority: soft_rst wins over start in the same cycle. soft_rst mid-group aborts; no further fb_we and no mbt_response for that group.
//  - FSM states: IDLE(0), SETUP(1), ITER(2), WRITE(3), DONE(4).
//    - IDLE: start=1 -> latch i_x, i_y; lane=0; -> SETUP.
//    - SETUP, 1 cycle: c_re = X_MIN + (x+lane)*X_STEP; c_im = Y_MIN + y*Y_STEP. Both truncated to signed 16 bit. zr=zi=0, iter=0. -> ITER.
//    - ITER, 1 cycle per step: form zr2, zi2, zrzi as 32-bit signed products.
//      - Escape test: (zr2+zi2) as 33-bit > (4<<24). If escaped or iter==MAX_ITER -> WRITE.
//      - Otherwise: zr <= (zr2-zi2)[27:12]+c_re; zi <= (2*zrzi)[27:12]+c_im; iter++.
//      - Wrap on the truncated 16-bit z is allowed; the escape test always uses untruncated sums.
//    - WRITE, 1 cycle: fb_we=1; fb_addr = y*FB_W + x + lane; fb_data = iter.
//      - lane<3 -> lane++, SETUP. lane==3 -> DONE.
//    - DONE: mbt_response=1 for exactly this one cycle; -> IDLE.
//  - Latency: pixel with count k takes k+3 cycles. A group of uniform k: DONE is entered 4*(k+3) edges after the start-sampling edge.
//  - start while busy is ignored; no queuing.
//  - fb_we is high only in WRITE, never two consecutive cycles without pack. fb_addr/fb_data are valid only while fb_we=1.
//  - Last pixel x=799, y=599 -> fb_addr 479999; no wrap check inside the engine.
// CONFIGURATION
//  - MBT_PACK4_EN defined:
//    - WRITE stores count into lane slot [lane*ITER_W +: ITER_W] of a pack register, with no fb_we for lanes 0-2.
//    - After lane 3: single fb_we with fb_addr=(y*FB_W+x)>>2 and fb_data = 4*ITER_W packed word; lane0 in LSBs.
//  - MBT_PACK4_EN undefined: 4 individual ITER_W writes as above.
// TESTING
//  - Defaults; start x=0,y=0 -> 4 writes at addr 0..3, data 1 each; mbt_response 16 edges after start, 1 cycle wide.
//  - X_MIN=X_STEP=Y_MIN=Y_STEP=0 (c=0), start x=8,y=2 -> 4 writes at addr 1608..1611, data 255; response at 4*258 edges.
//  - soft_rst asserted during lane 1 ITER -> exactly 1 write seen, no mbt_response, busy=0 next cycle. A subsequent start runs normally.
//  - start re-pulsed while busy, plus start and soft_rst in the same cycle -> both ignored; state stays IDLE / group unaffected.
//  - MBT_PACK4_EN with c=0 setup, start x=796,y=599 -> single write addr 119999, data 32'hFFFFFFFF.
//  - rst mid-WRITE -> fb_we and all outputs 0 next cycle; DBG_state=0.

Source files
------------

// File: rtl/mbt_pixel_engine_if.sv
// Bus between the pixel-sweep controller and the Mandelbrot engine.
// MBT_PACK4_EN widens fb_data to four packed escape counts.
interface mbt_pixel_engine_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned ITER_W = 8
);
`ifdef MBT_PACK4_EN
    localparam int unsigned DATA_W = 4 * ITER_W;
`else
    localparam int unsigned DATA_W = ITER_W;
`endif

    logic              start;
    logic [15:0]       i_x;
    logic [15:0]       i_y;
    logic              mbt_response;
    logic              busy;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic [2:0]        DBG_state;

    modport master (
        output start, i_x, i_y,
        input  mbt_response, busy, fb_we, fb_addr, fb_data, DBG_state
    );

    modport slave (
        input  start, i_x, i_y,
        output mbt_response, busy, fb_we, fb_addr, fb_data, DBG_state
    );
endinterface

// File: rtl/mbt_pixel_engine.sv
// Fixed-point Q4.12 Mandelbrot escape-count engine for groups of 4 pixels.
// Optional MBT_PACK4_EN: one packed frame-buffer write per group instead of four.
module mbt_pixel_engine #(
    parameter int unsigned FB_W     = 800,
    parameter int unsigned ITER_W   = 8,
    parameter int unsigned MAX_ITER = 255,
    parameter int unsigned ADDR_W   = 19,
    parameter int          X_MIN    = -10240,
    parameter int          X_STEP   = 18,
    parameter int          Y_MIN    = -5120,
    parameter int          Y_STEP   = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                soft_rst,
    mbt_pixel_engine_if.slave   bus
);
`ifdef MBT_PACK4_EN
    localparam int unsigned DATA_W = 4 * ITER_W;
`else
    localparam int unsigned DATA_W = ITER_W;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ITER  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic signed [32:0] ESC_LIM  = 33'sd67108864;
    localparam logic [ITER_W-1:0]  ITER_CAP = ITER_W'(MAX_ITER);

    state_t             state;
    logic [15:0]        x_q;
    logic [15:0]        y_q;
    logic [1:0]         lane;
    logic [ITER_W-1:0]  iter;
    logic signed [15:0] c_re;
    logic signed [15:0] c_im;
    logic signed [15:0] zr;
    logic signed [15:0] zi;

    logic              resp_q;
    logic              busy_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
`ifdef MBT_PACK4_EN
    logic [3*ITER_W-1:0] pack_q;
`endif

    // Datapath: pixel constants, squared terms, escape test and next z
    logic signed [15:0] c_re_n;
    logic signed [15:0] c_im_n;
    logic signed [31:0] zr2;
    logic signed [31:0] zi2;
    logic signed [31:0] zrzi;
    logic signed [32:0] mag;
    logic               escaped;
    logic signed [15:0] zr_n;
    logic signed [15:0] zi_n;
    logic               stop_iter;

    assign c_re_n    = 16'(X_MIN + $signed(32'(x_q) + 32'(lane)) * X_STEP);
    assign c_im_n    = 16'(Y_MIN + $signed(32'(y_q)) * Y_STEP);
    assign zr2       = 32'(zr) * 32'(zr);
    assign zi2       = 32'(zi) * 32'(zi);
    assign zrzi      = 32'(zr) * 32'(zi);
    assign mag       = 33'(zr2) + 33'(zi2);
    assign escaped   = mag > ESC_LIM;
    // 2*zrzi then [27:12] is the same bit window as zrzi[26:11]
    assign zr_n      = 16'((zr2 - zi2) >>> 12) + c_re;
    assign zi_n      = 16'(zrzi >>> 11) + c_im;
    assign stop_iter = escaped || (iter == ITER_CAP);

    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            state  <= IDLE;
            x_q    <= '0;
            y_q    <= '0;
            lane   <= '0;
            iter   <= '0;
            c_re   <= '0;
            c_im   <= '0;
            zr     <= '0;
            zi     <= '0;
            resp_q <= 1'b0;
            busy_q <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
`ifdef MBT_PACK4_EN
            pack_q <= '0;
`endif
        end else begin
            resp_q <= 1'b0;
            we_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_q    <= bus.i_x;
                        y_q    <= bus.i_y;
                        lane   <= 2'd0;
                        busy_q <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    c_re  <= c_re_n;
                    c_im  <= c_im_n;
                    zr    <= '0;
                    zi    <= '0;
                    iter  <= '0;
                    state <= ITER;
                end
                ITER: begin
                    if (stop_iter) begin
                        state <= WRITE;
`ifdef MBT_PACK4_EN
                        if (lane == 2'd3) begin
                            we_q   <= 1'b1;
                            addr_q <= ADDR_W'((32'(y_q) * FB_W + 32'(x_q)) >> 2);
                            data_q <= {iter, pack_q};
                        end else begin
                            pack_q[32'(lane) * ITER_W +: ITER_W] <= iter;
                        end
`else
                        we_q   <= 1'b1;
                        addr_q <= ADDR_W'(32'(y_q) * FB_W + 32'(x_q) + 32'(lane));
                        data_q <= iter;
`endif
                    end else begin
                        zr   <= zr_n;
                        zi   <= zi_n;
                        iter <= iter + ITER_W'(1);
                    end
                end
                WRITE: begin
                    if (lane == 2'd3) begin
                        resp_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        lane  <= lane + 2'd1;
                        state <= SETUP;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.mbt_response = resp_q;
    assign bus.busy         = busy_q;
    assign bus.fb_we        = we_q;
    assign bus.fb_addr      = addr_q;
    assign bus.fb_data      = data_q;
    assign bus.DBG_state    = state;
endmodule

// File: tb/tb_mbt_pixel_engine.sv
// Directed bench for mbt_pixel_engine: default-constant and c=0 instances side by side.
module tb_mbt_pixel_engine;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned ITER_W = 8;
`ifdef MBT_PACK4_EN
    localparam int unsigned DATA_W = 32;
    localparam int          NW     = 1;
`else
    localparam int unsigned DATA_W = 8;
    localparam int          NW     = 4;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        soft_rst;
    logic        start;
    logic [15:0] ix;
    logic [15:0] iy;
    int          sel;

    int checks   = 0;
    int failures = 0;

    mbt_pixel_engine_if #(.ADDR_W(ADDR_W), .ITER_W(ITER_W)) bus0 ();
    mbt_pixel_engine_if #(.ADDR_W(ADDR_W), .ITER_W(ITER_W)) bus1 ();

    mbt_pixel_engine dut0 (.clk(clk), .rst(rst), .soft_rst(soft_rst), .bus(bus0));
    mbt_pixel_engine #(.X_MIN(0), .X_STEP(0), .Y_MIN(0), .Y_STEP(0))
        dut1 (.clk(clk), .rst(rst), .soft_rst(soft_rst), .bus(bus1));

    assign bus0.start = start && (sel == 0);
    assign bus1.start = start && (sel == 1);
    assign bus0.i_x   = ix;
    assign bus0.i_y   = iy;
    assign bus1.i_x   = ix;
    assign bus1.i_y   = iy;

    logic              o_resp, o_busy, o_we;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_data;
    logic [2:0]        o_state;

    always_comb begin
        o_resp  = (sel == 1) ? bus1.mbt_response : bus0.mbt_response;
        o_busy  = (sel == 1) ? bus1.busy         : bus0.busy;
        o_we    = (sel == 1) ? bus1.fb_we        : bus0.fb_we;
        o_addr  = (sel == 1) ? bus1.fb_addr      : bus0.fb_addr;
        o_data  = (sel == 1) ? bus1.fb_data      : bus0.fb_data;
        o_state = (sel == 1) ? bus1.DBG_state    : bus0.DBG_state;
    end

    logic [ADDR_W-1:0] wa[$];
    logic [DATA_W-1:0] wd[$];
    int                resp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int s, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        sel   = s;
        ix    = x;
        iy    = y;
        start = 1'b1;
    endtask

    // Edge n=0 is the start-sampling edge; outputs sampled 1 time unit after each edge
    task automatic collect(input int max_n, input int pulse_at, input int soft_at, output int resp_n);
        bit prev_we;
        resp_n  = -1;
        prev_we = 1'b0;
        wa.delete();
        wd.delete();
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", 64'(o_busy), 64'd1);
        chk("state_setup", 64'(o_state), 64'd1);
        for (int n = 1; n <= max_n && resp_n < 0; n++) begin
            @(posedge clk);
            #1;
            if (o_we) begin
                chk("we_not_back_to_back", 64'(prev_we), 64'd0);
                wa.push_back(o_addr);
                wd.push_back(o_data);
            end
            prev_we = o_we;
            if (o_resp) begin
                resp_n = n;
                chk("done_state", 64'(o_state), 64'd4);
            end
            if (n == pulse_at) begin
                ix    = 16'd100;
                start = 1'b1;
            end
            if (n == pulse_at + 1) start = 1'b0;
            if (soft_at > 0 && n == soft_at) soft_rst = 1'b1;
            if (soft_at > 0 && n == soft_at + 1) begin
                soft_rst = 1'b0;
                chk("abort_busy", 64'(o_busy), 64'd0);
                chk("abort_state", 64'(o_state), 64'd0);
                chk("abort_we", 64'(o_we), 64'd0);
            end
        end
        if (resp_n >= 0) begin
            @(posedge clk);
            #1;
            chk("resp_width", 64'(o_resp), 64'd0);
            chk("idle_after_done", 64'(o_busy), 64'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        soft_rst = 1'b0;
        start    = 1'b0;
        ix       = '0;
        iy       = '0;
        sel      = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp", 64'(o_resp), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_we", 64'(o_we), 64'd0);
        chk("rst_addr", 64'(o_addr), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_state", 64'(o_state), 64'd0);
        rst = 1'b0;

        // Group (0..3, 0): every pixel escapes after one step; start re-pulse mid-group ignored
        launch(0, 16'd0, 16'd0);
        collect(40, 5, -1, resp);
        chk("t1_resp_edge", 64'(resp), 64'd16);
        chk("t1_nwrites", 64'(wa.size()), 64'(NW));
`ifdef MBT_PACK4_EN
        if (wa.size() == 1) begin
            chk("t1_addr", 64'(wa[0]), 64'd0);
            chk("t1_data", 64'(wd[0]), 64'h01010101);
        end
`else
        for (int i = 0; i < wa.size(); i++) begin
            chk($sformatf("t1_addr%0d", i), 64'(wa[i]), 64'(i));
            chk($sformatf("t1_data%0d", i), 64'(wd[i]), 64'd1);
        end
`endif

        // c=0 never escapes: capped at 255 iterations
        launch(1, 16'd8, 16'd2);
        collect(1100, -1, -1, resp);
        chk("t2_resp_edge", 64'(resp), 64'd1032);
        chk("t2_nwrites", 64'(wa.size()), 64'(NW));
`ifdef MBT_PACK4_EN
        if (wa.size() == 1) begin
            chk("t2_addr", 64'(wa[0]), 64'd402);
            chk("t2_data", 64'(wd[0]), 64'hFFFFFFFF);
        end
`else
        for (int i = 0; i < wa.size(); i++) begin
            chk($sformatf("t2_addr%0d", i), 64'(wa[i]), 64'(1608 + i));
            chk($sformatf("t2_data%0d", i), 64'(wd[i]), 64'd255);
        end
`endif

        // Last group of the frame
        launch(1, 16'd796, 16'd599);
        collect(1100, -1, -1, resp);
        chk("t3_resp_edge", 64'(resp), 64'd1032);
        chk("t3_nwrites", 64'(wa.size()), 64'(NW));
`ifdef MBT_PACK4_EN
        if (wa.size() == 1) begin
            chk("t3_addr", 64'(wa[0]), 64'd119999);
            chk("t3_data", 64'(wd[0]), 64'hFFFFFFFF);
        end
`else
        for (int i = 0; i < wa.size(); i++) begin
            chk($sformatf("t3_addr%0d", i), 64'(wa[i]), 64'(479996 + i));
            chk($sformatf("t3_data%0d", i), 64'(wd[i]), 64'd255);
        end
`endif

        // soft_rst sampled while lane 1 is iterating
        launch(0, 16'd4, 16'd0);
        collect(20, -1, 5, resp);
        chk("t4_no_resp", 64'(resp), 64'hFFFFFFFFFFFFFFFF);
`ifdef MBT_PACK4_EN
        chk("t4_nwrites", 64'(wa.size()), 64'd0);
`else
        chk("t4_nwrites", 64'(wa.size()), 64'd1);
        if (wa.size() == 1) begin
            chk("t4_addr", 64'(wa[0]), 64'd4);
            chk("t4_data", 64'(wd[0]), 64'd1);
        end
`endif

        // Recovery: next group runs normally
        launch(0, 16'd0, 16'd1);
        collect(40, -1, -1, resp);
        chk("t5_resp_edge", 64'(resp), 64'd16);
        chk("t5_nwrites", 64'(wa.size()), 64'(NW));
`ifdef MBT_PACK4_EN
        if (wa.size() == 1) begin
            chk("t5_addr", 64'(wa[0]), 64'd200);
            chk("t5_data", 64'(wd[0]), 64'h01010101);
        end
`else
        for (int i = 0; i < wa.size(); i++) begin
            chk($sformatf("t5_addr%0d", i), 64'(wa[i]), 64'(800 + i));
            chk($sformatf("t5_data%0d", i), 64'(wd[i]), 64'd1);
        end
`endif

        // start together with soft_rst: soft_rst wins
        launch(0, 16'd0, 16'd0);
        soft_rst = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        soft_rst = 1'b0;
        chk("t6_busy", 64'(o_busy), 64'd0);
        chk("t6_state", 64'(o_state), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_busy_later", 64'(o_busy), 64'd0);
        chk("t6_we_later", 64'(o_we), 64'd0);

        // rst during the lane-3 WRITE cycle
        launch(0, 16'd0, 16'd0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("t7_pre_we", 64'(o_we), 64'd1);
        chk("t7_pre_state", 64'(o_state), 64'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t7_we", 64'(o_we), 64'd0);
        chk("t7_state", 64'(o_state), 64'd0);
        chk("t7_busy", 64'(o_busy), 64'd0);
        chk("t7_addr", 64'(o_addr), 64'd0);
        chk("t7_data", 64'(o_data), 64'd0);
        chk("t7_resp", 64'(o_resp), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
